// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue: entry layout and deq_cnt encodings.
package fetch_pkg;

    localparam int unsigned PC_WIDTH    = 16;
    localparam int unsigned INSTR_WIDTH = 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        DEQ_NONE = 2'd0,
        DEQ_ONE  = 2'd1,
        DEQ_TWO  = 2'd2
    } deq_cnt_e;

    // Decode may only take two per cycle; the unused encoding 3 behaves as two.
    function automatic logic [1:0] clip_deq(input logic [1:0] req);
        return (req == 2'd3) ? 2'(DEQ_TWO) : req;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode side bundle of the fetch queue; stats ports exist only with FETCHQ_STATS_EN.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                   flush;
    logic [1:0]             in_valid;
    logic [INSTR_WIDTH-1:0] in_instr1;
    logic [INSTR_WIDTH-1:0] in_instr2;
    logic [PC_WIDTH-1:0]    in_pc;
    logic                   pc_write;
    logic                   out_valid1;
    logic                   out_valid2;
    logic [INSTR_WIDTH-1:0] out_instr1;
    logic [INSTR_WIDTH-1:0] out_instr2;
    logic [PC_WIDTH-1:0]    out_pc1;
    logic [PC_WIDTH-1:0]    out_pc2;
    logic [1:0]             deq_cnt;
    logic [CW-1:0]          occupancy;
`ifdef FETCHQ_STATS_EN
    logic [15:0]            stall_cycles;
    logic [15:0]            flush_count;
`endif

    modport master (
        output flush, in_valid, in_instr1, in_instr2, in_pc, deq_cnt,
        input  pc_write, out_valid1, out_valid2, out_instr1, out_instr2,
               out_pc1, out_pc2, occupancy
`ifdef FETCHQ_STATS_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  flush, in_valid, in_instr1, in_instr2, in_pc, deq_cnt,
        output pc_write, out_valid1, out_valid2, out_instr1, out_instr2,
               out_pc1, out_pc2, occupancy
`ifdef FETCHQ_STATS_EN
        , output stall_cycles, flush_count
`endif
    );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH-entry register array with two write ports and two asynchronous read ports.
module fetch_queue_ram
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
)
(
    input  logic                       clk,
    input  logic                       we0,
    input  logic [$clog2(DEPTH)-1:0]   waddr0,
    input  fetch_entry_t               wdata0,
    input  logic                       we1,
    input  logic [$clog2(DEPTH)-1:0]   waddr1,
    input  fetch_entry_t               wdata1,
    input  logic [$clog2(DEPTH)-1:0]   raddr0,
    output fetch_entry_t               rdata0,
    input  logic [$clog2(DEPTH)-1:0]   raddr1,
    output fetch_entry_t               rdata1
);

    fetch_entry_t mem [DEPTH];

    // Contents are don't-care until written, so no reset is applied.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Two-in/two-out instruction buffer between fetch and decode with flush on redirect.
// Optional FETCHQ_STATS_EN adds saturating stall_cycles and flush_count counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
)
(
    input  logic            clk,
    input  logic            rst_n,
    fetch_queue_if.slave    bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and at least 4");
    end

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [1:0]    enq_n;
    logic [1:0]    deq_req;
    logic [1:0]    deq_n;
    logic          we0;
    logic          we1;
    fetch_entry_t  wdata0;
    fetch_entry_t  wdata1;
    fetch_entry_t  rdata0;
    fetch_entry_t  rdata1;

    // Uses pre-dequeue count so an accepted full bundle always has room.
    assign bus.pc_write = (count <= CW'(DEPTH - 2)) && !bus.flush;

    always_comb begin
        enq_n = '0;
        we0   = 1'b0;
        we1   = 1'b0;
        if (bus.pc_write) begin
            unique case (bus.in_valid)
                2'b01: begin
                    enq_n = 2'd1;
                    we0   = 1'b1;
                end
                2'b11: begin
                    enq_n = 2'd2;
                    we0   = 1'b1;
                    we1   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wdata0 = '{pc: bus.in_pc,         instr: bus.in_instr1};
    assign wdata1 = '{pc: bus.in_pc + 1'b1,  instr: bus.in_instr2};

    assign deq_req = clip_deq(bus.deq_cnt);
    assign deq_n   = (CW'(deq_req) > count) ? count[1:0] : deq_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(deq_n);
            wr_ptr <= wr_ptr + PW'(enq_n);
            count  <= count + CW'(enq_n) - CW'(deq_n);
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (wr_ptr),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (wr_ptr + 1'b1),
        .wdata1 (wdata1),
        .raddr0 (rd_ptr),
        .rdata0 (rdata0),
        .raddr1 (rd_ptr + 1'b1),
        .rdata1 (rdata1)
    );

    assign bus.occupancy  = count;
    assign bus.out_valid1 = (count != '0);
    assign bus.out_valid2 = (count >= CW'(2));
    assign bus.out_instr1 = bus.out_valid1 ? rdata0.instr : '0;
    assign bus.out_pc1    = bus.out_valid1 ? rdata0.pc    : '0;
    assign bus.out_instr2 = bus.out_valid2 ? rdata1.instr : '0;
    assign bus.out_pc2    = bus.out_valid2 ? rdata1.pc    : '0;

`ifdef FETCHQ_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!bus.pc_write && !bus.flush && stall_cycles != '1)
                stall_cycles <= stall_cycles + 16'd1;
            if (bus.flush && flush_count != '1)
                flush_count <= flush_count + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cycles;
    assign bus.flush_count  = flush_count;
`endif

    a_no_upper_only: assert property (
        @(posedge clk) disable iff (!rst_n) bus.in_valid != 2'b10
    ) else $error("fetch_queue: in_valid=2'b10 is not a legal bundle");

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue of {pc, instr} tracks expected decode order.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst_n;
    int unsigned checks;
    int unsigned errors;
    fetch_entry_t sb[$];
    logic [15:0] pc_gen;

    fetch_queue_if #(.DEPTH(DEPTH)) fq ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [15:0] pc, input logic second);
        return {second ? 16'hB00B : 16'hA00A, pc};
    endfunction

    task automatic drive_idle();
        fq.flush     = 1'b0;
        fq.in_valid  = 2'b00;
        fq.in_instr1 = '0;
        fq.in_instr2 = '0;
        fq.in_pc     = '0;
        fq.deq_cnt   = 2'd0;
    endtask

    // Drive one cycle, compare DUT outputs with the scoreboard head, then advance the model.
    task automatic step(input logic [1:0] v, input logic [15:0] pc,
                        input logic [1:0] d, input logic f);
        logic         pw;
        int unsigned  dq;
        int unsigned  sz;
        fetch_entry_t e;
        fq.in_valid  = v;
        fq.in_pc     = pc;
        fq.in_instr1 = mk_instr(pc, 1'b0);
        fq.in_instr2 = mk_instr(pc + 16'd1, 1'b1);
        fq.deq_cnt   = d;
        fq.flush     = f;
        #1;
        sz = sb.size();
        pw = (sz <= DEPTH - 2) && !f;
        check("pc_write",   64'(fq.pc_write),   64'(pw));
        check("occupancy",  64'(fq.occupancy),  64'(sz));
        check("out_valid1", 64'(fq.out_valid1), 64'(sz >= 1));
        check("out_valid2", 64'(fq.out_valid2), 64'(sz >= 2));
        check("out_pc1",    64'(fq.out_pc1),    64'(sz >= 1 ? sb[0].pc    : 16'h0));
        check("out_instr1", 64'(fq.out_instr1), 64'(sz >= 1 ? sb[0].instr : 32'h0));
        check("out_pc2",    64'(fq.out_pc2),    64'(sz >= 2 ? sb[1].pc    : 16'h0));
        check("out_instr2", 64'(fq.out_instr2), 64'(sz >= 2 ? sb[1].instr : 32'h0));
        if (f) begin
            sb.delete();
        end else begin
            dq = (d == 2'd3) ? 2 : int'(d);
            if (dq > sz) dq = sz;
            repeat (dq) void'(sb.pop_front());
            if (pw && (v == 2'b01 || v == 2'b11)) begin
                e.pc = pc; e.instr = mk_instr(pc, 1'b0);
                sb.push_back(e);
            end
            if (pw && v == 2'b11) begin
                e.pc = pc + 16'd1; e.instr = mk_instr(pc + 16'd1, 1'b1);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        #1;
        check("rst_occupancy",  64'(fq.occupancy),  64'(0));
        check("rst_pc_write",   64'(fq.pc_write),   64'(1));
        check("rst_out_valid1", 64'(fq.out_valid1), 64'(0));
        check("rst_out_valid2", 64'(fq.out_valid2), 64'(0));
        check("rst_out_pc1",    64'(fq.out_pc1),    64'(0));
        check("rst_out_instr2", 64'(fq.out_instr2), 64'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [1:0] d);
        step(2'b11, pc_gen, d, 1'b0);
        pc_gen = pc_gen + 16'd2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        pc_gen = 16'h0100;
        drive_idle();
        @(posedge clk);
        #1;

`ifdef FETCHQ_STATS_EN
        do_reset();
        repeat (4) push2(2'd0);
        repeat (3) step(2'b11, 16'h0900, 2'd0, 1'b0);
        step(2'b00, 16'h0, 2'd0, 1'b1);
        check("stall_cycles", 64'(fq.stall_cycles), 64'(3));
        check("flush_count",  64'(fq.flush_count),  64'(1));
`endif

        // First bundle, visible one cycle later with pc and pc+1.
        do_reset();
        step(2'b11, 16'h0010, 2'd0, 1'b0);
        check("first_pc2", 64'(fq.out_pc2), 64'(16'h0011));
        step(2'b00, 16'h0, 2'd0, 1'b0);

        // Fill to DEPTH, then blocked full push with a concurrent dequeue of two.
        repeat (3) push2(2'd0);
        step(2'b11, 16'h0800, 2'd0, 1'b0);
        step(2'b11, 16'h0800, 2'd2, 1'b0);
        check("after_full_occ", 64'(fq.occupancy), 64'(6));

        // Single push to DEPTH-1 blocks fetch until one entry drains.
        step(2'b01, pc_gen, 2'd0, 1'b0);
        pc_gen = pc_gen + 16'd1;
        step(2'b11, 16'h0800, 2'd1, 1'b0);
        step(2'b00, 16'h0, 2'd0, 1'b0);

        // Reset mid-operation drops everything immediately.
        do_reset();

        // Mixed traffic across pointer wrap, including the clipped encoding 3.
        for (int i = 0; i < 24; i++) begin
            logic [1:0] v;
            logic [1:0] d;
            v = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            d = 2'($urandom_range(1, 3));
            step(v, pc_gen, d, 1'b0);
            if (fq.occupancy != 0 || v != 2'b00)
                pc_gen = pc_gen + ((v == 2'b11) ? 16'd2 : 16'd1);
        end
        repeat (5) step(2'b00, 16'h0, 2'd2, 1'b0);

        // Flush at occupancy 5 beats a concurrent push and dequeue.
        push2(2'd0);
        push2(2'd0);
        step(2'b01, 16'h0500, 2'd0, 1'b0);
        step(2'b11, 16'h0600, 2'd2, 1'b1);
        step(2'b11, 16'h0700, 2'd0, 1'b0);
        check("post_flush_pc1", 64'(fq.out_pc1), 64'(16'h0700));

        // Empty queue ignores a dequeue request.
        step(2'b00, 16'h0, 2'd2, 1'b0);
        step(2'b00, 16'h0, 2'd2, 1'b0);
        step(2'b00, 16'h0, 2'd2, 1'b0);

        // PC of the younger instruction wraps modulo 2^16.
        step(2'b11, 16'hFFFF, 2'd0, 1'b0);
        check("wrap_pc2", 64'(fq.out_pc2), 64'(16'h0000));
        step(2'b00, 16'h0, 2'd2, 1'b0);
        step(2'b00, 16'h0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
